// File: rtl/mvu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mvu_pkg
//  Description : Shared types and helpers for the matrix-vector-activation
//                engine: FSM state encoding, counter-width helper and the
//                output narrowing function.
//                Optional feature macro MVU_SATURATE_EN selects clamping
//                narrowing. When it is undefined, narrowing wraps in
//                two's complement.
//  Revision    : 1.0 - initial release
// ============================================================================
package mvu_pkg;

    typedef enum logic [2:0] {
        LOAD_W   = 3'd0,
        LOAD_B   = 3'd1,
        READ_ACT = 3'd2,
        COMPUTE  = 3'd3,
        POST     = 3'd4,
        EMIT     = 3'd5
    } mvu_state_e;

    // Width of a counter indexing n items. It is never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Narrow a sign-extended result to out_width bits. The caller keeps only
    // the low out_width bits of the return value.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] acc,
                                                      input int                 out_width);
`ifdef MVU_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_width - 1));
        if (acc > hi)      return hi;
        else if (acc < lo) return lo;
        else               return acc;
`else
        return acc & ((64'sd1 <<< out_width) - 64'sd1);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvu_simd_dot.sv
`default_nettype none
// ============================================================================
//  Module      : mvu_simd_dot
//  Description : Combinational SIMD-wide signed dot product for one PE lane.
//                Each product is kept at full precision and sign-extended to
//                ACC_WIDTH. The sum wraps modulo 2^ACC_WIDTH.
//  Ports       : i_w   - SIMD signed weights, lane s at [s*WEIGHT_WIDTH +:]
//                i_a   - SIMD signed activations, lane s at [s*ACT_WIDTH +:]
//                o_dot - signed dot product, ACC_WIDTH bits
//  Revision    : 1.0 - initial release
// ============================================================================
module mvu_simd_dot
    import mvu_pkg::*;
#(
    parameter int SIMD         = 8,
    parameter int ACT_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32
) (
    input  logic        [SIMD*WEIGHT_WIDTH-1:0] i_w,
    input  logic        [SIMD*ACT_WIDTH-1:0]    i_a,
    output logic signed [ACC_WIDTH-1:0]         o_dot
);
    localparam int PW = WEIGHT_WIDTH + ACT_WIDTH;

    logic signed [PW-1:0] w_prod [SIMD];

    for (genvar s = 0; s < SIMD; s++) begin : g_lane
        assign w_prod[s] = PW'($signed(i_w[s*WEIGHT_WIDTH +: WEIGHT_WIDTH]))
                         * PW'($signed(i_a[s*ACT_WIDTH +: ACT_WIDTH]));
    end

    always_comb begin
        o_dot = '0;
        for (int s = 0; s < SIMD; s++) begin
            o_dot = o_dot + ACC_WIDTH'(w_prod[s]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mvu_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mvu_stream_engine
//  Description : Matrix-vector-activation engine. Loads an MH x MW weight
//                matrix and MH biases over AXI-Stream. It then turns each
//                MW-element activation vector into NF = MH/PE output folds of
//                PE lanes, with bias add, optional ReLU and narrowing.
//                Optional feature macro MVU_SATURATE_EN selects saturating
//                narrowing instead of wrapping.
//  Ports       : ap_clk / ap_rst_n   - clock, synchronous active-low reset
//                s_axis_weights_*    - weight tiles, nf-major / sf-minor
//                s_axis_bias_*       - one PE-wide bias word per fold
//                s_axis_activations_*- SIMD-wide activation slices
//                m_axis_features_*   - one PE-wide output fold, tlast on last
//                relu_en             - ReLU enable, sampled on COMPUTE entry
//                reload              - request weight/bias reload
//                weights_loaded      - weights and biases are valid
//  Revision    : 1.0 - initial release
// ============================================================================
module mvu_stream_engine
    import mvu_pkg::*;
#(
    parameter int MW           = 64,
    parameter int MH           = 128,
    parameter int PE           = 16,
    parameter int SIMD         = 8,
    parameter int ACT_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_WIDTH    = 16
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic [PE*SIMD*WEIGHT_WIDTH-1:0] s_axis_weights_tdata,
    input  logic                           s_axis_weights_tvalid,
    output logic                           s_axis_weights_tready,
    input  logic [PE*BIAS_WIDTH-1:0]       s_axis_bias_tdata,
    input  logic                           s_axis_bias_tvalid,
    output logic                           s_axis_bias_tready,
    input  logic [SIMD*ACT_WIDTH-1:0]      s_axis_activations_tdata,
    input  logic                           s_axis_activations_tvalid,
    output logic                           s_axis_activations_tready,
    output logic [PE*OUT_WIDTH-1:0]        m_axis_features_tdata,
    output logic                           m_axis_features_tvalid,
    input  logic                           m_axis_features_tready,
    output logic                           m_axis_features_tlast,
    input  logic                           relu_en,
    input  logic                           reload,
    output logic                           weights_loaded
);
    localparam int SF  = MW / SIMD;
    localparam int NF  = MH / PE;
    localparam int WAW = cnt_width(NF * SF);
    localparam int NFW = cnt_width(NF);
    localparam int SFW = cnt_width(SF);
    localparam int CCW = cnt_width(SF + 1);
    localparam int TW  = PE * SIMD * WEIGHT_WIDTH;
    localparam int AVW = SIMD * ACT_WIDTH;

    localparam logic [WAW-1:0] c_W_LAST  = WAW'(NF * SF - 1);
    localparam logic [NFW-1:0] c_NF_LAST = NFW'(NF - 1);
    localparam logic [SFW-1:0] c_SF_LAST = SFW'(SF - 1);
    localparam logic [CCW-1:0] c_CC_LAST = CCW'(SF);

    if (MW % SIMD != 0) begin : g_chk_mw
        $error("mvu_stream_engine: MW must be a multiple of SIMD");
    end
    if (MH % PE != 0) begin : g_chk_mh
        $error("mvu_stream_engine: MH must be a multiple of PE");
    end
    if (ACC_WIDTH < BIAS_WIDTH || OUT_WIDTH > ACC_WIDTH) begin : g_chk_w
        $error("mvu_stream_engine: need ACC_WIDTH >= BIAS_WIDTH and OUT_WIDTH <= ACC_WIDTH");
    end

    mvu_state_e               r_state, w_state_nxt;
    logic                     r_active;     // low for the cycle after a reset edge
    logic [WAW-1:0]           r_wcnt, w_rd_addr;
    logic [NFW-1:0]           r_bcnt, r_nf;
    logic [SFW-1:0]           r_acnt;
    logic [CCW-1:0]           r_cc;         // COMPUTE cycle 0..SF
    logic                     r_relu_q, r_loaded, r_out_last;
    logic [PE*OUT_WIDTH-1:0]  r_out_data, w_out_data;
    logic [TW-1:0]            r_wmem [NF*SF];
    logic [PE*BIAS_WIDTH-1:0] r_bmem [NF];
    logic [AVW-1:0]           r_abuf [SF];
    logic [TW-1:0]            r_wrd;
    logic [AVW-1:0]           r_arow;
    logic [PE*BIAS_WIDTH-1:0] w_bias_word;
    logic                     w_w_fire, w_b_fire, w_a_fire, w_o_fire, w_reload, w_rd_en;

    // Readies depend only on registered state.
    assign s_axis_weights_tready     = r_active && (r_state == LOAD_W);
    assign s_axis_bias_tready        = r_active && (r_state == LOAD_B);
    assign s_axis_activations_tready = r_active && (r_state == READ_ACT);
    assign m_axis_features_tvalid    = (r_state == EMIT);
    assign m_axis_features_tdata     = r_out_data;
    assign m_axis_features_tlast     = r_out_last;
    assign weights_loaded            = r_loaded;

    assign w_w_fire = s_axis_weights_tvalid && s_axis_weights_tready;
    assign w_b_fire = s_axis_bias_tvalid && s_axis_bias_tready;
    assign w_a_fire = s_axis_activations_tvalid && s_axis_activations_tready;
    assign w_o_fire = m_axis_features_tvalid && m_axis_features_tready;
    // Reload is honoured only before the first beat of a vector. It wins over
    // a coincident activation beat, which is then dropped.
    assign w_reload = s_axis_activations_tready && reload && (r_acnt == '0);
    assign w_rd_en  = (r_state == COMPUTE) && (r_cc != c_CC_LAST);
    assign w_rd_addr   = WAW'(int'(r_nf) * SF + int'(r_cc));
    assign w_bias_word = r_bmem[r_nf];

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) r_state <= LOAD_W;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD_W:   if (w_w_fire && r_wcnt == c_W_LAST) w_state_nxt = LOAD_B;
            LOAD_B:   if (w_b_fire && r_bcnt == c_NF_LAST) w_state_nxt = READ_ACT;
            READ_ACT: if (w_reload) w_state_nxt = LOAD_W;
                      else if (w_a_fire && r_acnt == c_SF_LAST) w_state_nxt = COMPUTE;
            COMPUTE:  if (r_cc == c_CC_LAST) w_state_nxt = POST;
            POST:     w_state_nxt = EMIT;
            EMIT:     if (w_o_fire) w_state_nxt = (r_nf == c_NF_LAST) ? READ_ACT : COMPUTE;
            default:  w_state_nxt = LOAD_W;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_active   <= 1'b0;
            r_wcnt     <= '0;
            r_bcnt     <= '0;
            r_acnt     <= '0;
            r_cc       <= '0;
            r_nf       <= '0;
            r_relu_q   <= 1'b0;
            r_loaded   <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_w_fire) r_wcnt <= (r_wcnt == c_W_LAST) ? '0 : r_wcnt + 1'b1;
            if (w_b_fire) r_bcnt <= (r_bcnt == c_NF_LAST) ? '0 : r_bcnt + 1'b1;
            if (w_b_fire && r_bcnt == c_NF_LAST) r_loaded <= 1'b1;
            if (w_reload) r_loaded <= 1'b0;
            else if (w_a_fire) r_acnt <= (r_acnt == c_SF_LAST) ? '0 : r_acnt + 1'b1;
            if (r_state == COMPUTE) r_cc <= (r_cc == c_CC_LAST) ? '0 : r_cc + 1'b1;
            if (w_o_fire) r_nf <= (r_nf == c_NF_LAST) ? '0 : r_nf + 1'b1;
            if (w_state_nxt == COMPUTE && r_state != COMPUTE) r_relu_q <= relu_en;
            if (r_state == POST) begin
                r_out_data <= w_out_data;
                r_out_last <= (r_nf == c_NF_LAST);
            end
        end
    end

    // Storage is not cleared by reset; it is rewritten on every load.
    always_ff @(posedge ap_clk) begin
        if (w_w_fire) r_wmem[r_wcnt] <= s_axis_weights_tdata;
        if (w_b_fire) r_bmem[r_bcnt] <= s_axis_bias_tdata;
        if (w_a_fire) r_abuf[r_acnt] <= s_axis_activations_tdata;
        if (w_rd_en) begin
            r_wrd  <= r_wmem[w_rd_addr];
            r_arow <= r_abuf[SFW'(r_cc)];
        end
    end

    // COMPUTE cycle 0 issues the first read and clears acc. Cycles 1..SF
    // accumulate the tile read one cycle earlier.
    for (genvar p = 0; p < PE; p++) begin : g_pe
        logic signed [ACC_WIDTH-1:0] w_dot, r_acc, w_bias_ext, w_sum, w_post;

        mvu_simd_dot #(
            .SIMD         (SIMD),
            .ACT_WIDTH    (ACT_WIDTH),
            .WEIGHT_WIDTH (WEIGHT_WIDTH),
            .ACC_WIDTH    (ACC_WIDTH)
        ) u_dot (
            .i_w   (r_wrd[p*SIMD*WEIGHT_WIDTH +: SIMD*WEIGHT_WIDTH]),
            .i_a   (r_arow),
            .o_dot (w_dot)
        );

        always_ff @(posedge ap_clk) begin
            if (r_state == COMPUTE) r_acc <= (r_cc == '0) ? '0 : r_acc + w_dot;
        end

        assign w_bias_ext = ACC_WIDTH'($signed(w_bias_word[p*BIAS_WIDTH +: BIAS_WIDTH]));
        assign w_sum      = r_acc + w_bias_ext;
        assign w_post     = (r_relu_q && w_sum[ACC_WIDTH-1]) ? '0 : w_sum;
        assign w_out_data[p*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sat_narrow(64'(w_post), OUT_WIDTH));
    end

endmodule
`default_nettype wire

// File: tb/tb_mvu_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvu_stream_engine
//  Description : Directed self-checking bench for mvu_stream_engine in the
//                MW=4 MH=4 PE=2 SIMD=2 OUT_WIDTH=8 configuration (SF=2, NF=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mvu_stream_engine;
    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] w_data, b_data;
    logic [15:0] a_data;
    logic        w_valid, b_valid, a_valid;
    logic        w_ready, b_ready, a_ready;
    logic [15:0] m_data;
    logic        m_valid, m_ready, m_last;
    logic        relu_en, reload, loaded;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mvu_stream_engine #(
        .MW(4), .MH(4), .PE(2), .SIMD(2), .ACT_WIDTH(8), .WEIGHT_WIDTH(8),
        .BIAS_WIDTH(16), .ACC_WIDTH(32), .OUT_WIDTH(8)
    ) dut (
        .ap_clk                    (clk),
        .ap_rst_n                  (rst_n),
        .s_axis_weights_tdata      (w_data),
        .s_axis_weights_tvalid     (w_valid),
        .s_axis_weights_tready     (w_ready),
        .s_axis_bias_tdata         (b_data),
        .s_axis_bias_tvalid        (b_valid),
        .s_axis_bias_tready        (b_ready),
        .s_axis_activations_tdata  (a_data),
        .s_axis_activations_tvalid (a_valid),
        .s_axis_activations_tready (a_ready),
        .m_axis_features_tdata     (m_data),
        .m_axis_features_tvalid    (m_valid),
        .m_axis_features_tready    (m_ready),
        .m_axis_features_tlast     (m_last),
        .relu_en                   (relu_en),
        .reload                    (reload),
        .weights_loaded            (loaded)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All push tasks are entered at a negedge and return at the negedge that
    // follows the transferring posedge.
    task automatic push_w(input logic [31:0] d);
        int n = 0;
        w_data = d; w_valid = 1'b1;
        while (!w_ready && n < TO) begin @(negedge clk); n++; end
        if (!w_ready) check("w_timeout", 0, 1);
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] d);
        int n = 0;
        b_data = d; b_valid = 1'b1;
        while (!b_ready && n < TO) begin @(negedge clk); n++; end
        if (!b_ready) check("b_timeout", 0, 1);
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic push_a(input logic [15:0] d);
        int n = 0;
        a_data = d; a_valid = 1'b1;
        while (!a_ready && n < TO) begin @(negedge clk); n++; end
        if (!a_ready) check("a_timeout", 0, 1);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] w, input logic [15:0] b);
        for (int k = 0; k < 4; k++) push_w({4{w}});
        for (int k = 0; k < 2; k++) push_b({2{b}});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!m_valid && n < TO) begin @(negedge clk); n++; end
        if (!m_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic get_fold(input string tag, input logic [15:0] exp_d, input logic exp_l);
        int n;
        wait_valid(n);
        check({tag, "_data"}, m_data, exp_d);
        check({tag, "_last"}, m_last, exp_l);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; w_valid = 0; b_valid = 0; a_valid = 0;
        w_data = '0; b_data = '0; a_data = '0;
        m_ready = 1'b1; relu_en = 1'b0; reload = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {m_valid, m_data, m_last, loaded}, '0);
        check("rst_readies", {w_ready, b_ready, a_ready}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        check("w_ready_after_rst", w_ready, 1);

        // 1: unit weights, zero bias -> 1+2+3+4 = 10 per lane
        load(8'h01, 16'h0000);
        check("loaded_t1", loaded, 1);
        check("a_ready_t1", a_ready, 1);
        push_a(16'h0201);
        push_a(16'h0403);
        wait_valid(lat);
        check("latency", lat, 4);
        get_fold("t1_f1", 16'h0A0A, 1'b0);
        check("valid_drop", m_valid, 0);
        get_fold("t1_f2", 16'h0A0A, 1'b1);

        // 2 + 3: reload, weights -1, bias 3 -> -7; hold fold 1 under backpressure
        reload = 1'b1; @(negedge clk); reload = 1'b0;
        check("reload_w_ready", w_ready, 1);
        check("reload_loaded", loaded, 0);
        load(8'hFF, 16'h0003);
        m_ready = 1'b0;
        push_a(16'h0201);
        push_a(16'h0403);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {m_valid, m_data, m_last, w_ready, b_ready, a_ready},
                  {1'b1, 16'hF9F9, 1'b0, 3'b000});
            @(negedge clk);
        end
        m_ready = 1'b1;
        get_fold("t2_f1", 16'hF9F9, 1'b0);
        get_fold("t2_f2", 16'hF9F9, 1'b1);
        relu_en = 1'b1;
        push_a(16'h0201);
        push_a(16'h0403);
        get_fold("relu_f1", 16'h0000, 1'b0);
        get_fold("relu_f2", 16'h0000, 1'b1);
        relu_en = 1'b0;

        // 4: 100+100+50+50 = 300 -> clamp to 127 or wrap to 44
        reload = 1'b1; @(negedge clk); reload = 1'b0;
        load(8'h01, 16'h0000);
        push_a(16'h6464);
        push_a(16'h3232);
`ifdef MVU_SATURATE_EN
        get_fold("narrow_f1", 16'h7F7F, 1'b0);
        get_fold("narrow_f2", 16'h7F7F, 1'b1);
`else
        get_fold("narrow_f1", 16'h2C2C, 1'b0);
        get_fold("narrow_f2", 16'h2C2C, 1'b1);
`endif

        // 5: reset mid-COMPUTE
        push_a(16'h0201);
        push_a(16'h0403);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_state", {m_valid, loaded, a_ready, w_ready, b_ready}, 5'b00000);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_w_ready", w_ready, 1);

        // 6: reload before any beat, weights 2 -> 20; mid-vector reload ignored
        load(8'h01, 16'h0000);
        reload = 1'b1; @(negedge clk); reload = 1'b0;
        check("t6_reload", {w_ready, loaded, a_ready}, 3'b100);
        load(8'h02, 16'h0000);
        check("t6_loaded", loaded, 1);
        push_a(16'h0201);
        reload = 1'b1; @(negedge clk); reload = 1'b0;
        check("t6_midvec_reload", {a_ready, w_ready, loaded}, 3'b101);
        push_a(16'h0403);
        get_fold("t6_f1", 16'h1414, 1'b0);
        get_fold("t6_f2", 16'h1414, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
